// File: rtl/aes_key_schedule_if.sv
// aes_key_schedule_if: key-load and round-key handshake bundle for aes_key_schedule.
//   start/key_in        : load request and 128-bit cipher key (byte 0 at [127:120])
//   busy                : expansion in progress
//   rk_valid/rk_ready   : round-key handshake
//   rk_key/rk_round     : current round key and its index
//   done                : one-cycle pulse after the last round key is accepted
//   rd_idx/rd_key/keys_ready : key-store read port, present only with AES_KEY_STORE_EN
// master = controller/consumer side, slave = key schedule.
interface aes_key_schedule_if #(
  parameter int unsigned RIDX_W = 4
);
  logic              start;
  logic [127:0]      key_in;
  logic              busy;
  logic              rk_valid;
  logic              rk_ready;
  logic [127:0]      rk_key;
  logic [RIDX_W-1:0] rk_round;
  logic              done;
`ifdef AES_KEY_STORE_EN
  logic [RIDX_W-1:0] rd_idx;
  logic [127:0]      rd_key;
  logic              keys_ready;
`endif

  modport master (
    output start, key_in, rk_ready,
`ifdef AES_KEY_STORE_EN
    output rd_idx,
    input  rd_key, keys_ready,
`endif
    input  busy, rk_valid, rk_key, rk_round, done
  );

  modport slave (
    input  start, key_in, rk_ready,
`ifdef AES_KEY_STORE_EN
    input  rd_idx,
    output rd_key, keys_ready,
`endif
    output busy, rk_valid, rk_key, rk_round, done
  );
endinterface

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: sequential AES-128 key expansion. Loads a cipher key and
// emits round keys 0..ROUNDS one per rk handshake, computing each next key on
// the fly from the current one.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : aes_key_schedule_if.slave (start/key_in, busy, rk_* handshake, done)
// Parameters:
//   ROUNDS : index of the last round key (1..10, limited by the rcon sequence)
//   RIDX_W : width of rk_round, 2**RIDX_W > ROUNDS
// Optional feature macro AES_KEY_STORE_EN: keeps every accepted round key in a
// ROUNDS+1 entry store readable through rd_idx/rd_key, and flags keys_ready
// when a full schedule has been captured (for reverse-order decryption).
module aes_key_schedule #(
  parameter int unsigned ROUNDS = 10,
  parameter int unsigned RIDX_W = 4
) (
  input logic              clk,
  input logic              rst,
  aes_key_schedule_if.slave bus
);

  localparam logic [RIDX_W-1:0] LAST = RIDX_W'(ROUNDS);

  // AES S-box, byte 0x00 in the most significant position.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state;
  logic              busy;
  logic              rk_valid;
  logic [127:0]      rk_key;
  logic [RIDX_W-1:0] rk_round;
  logic              done;
  logic [7:0]        rcon;
  logic [127:0]      next_key;
  logic [7:0]        next_rcon;

  always_comb begin
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = rk_key[127:96];
    w1 = rk_key[95:64];
    w2 = rk_key[63:32];
    w3 = rk_key[31:0];
    t  = subword({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key  = {n0, n1, n2, n3};
    next_rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  end

`ifdef AES_KEY_STORE_EN
  logic keys_ready;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_key   <= '0;
      rk_round <= '0;
      done     <= 1'b0;
      rcon     <= 8'h01;
`ifdef AES_KEY_STORE_EN
      keys_ready <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= EMIT;
            busy     <= 1'b1;
            rk_valid <= 1'b1;
            rk_key   <= bus.key_in;
            rk_round <= '0;
            rcon     <= 8'h01;
`ifdef AES_KEY_STORE_EN
            keys_ready <= 1'b0;
`endif
          end
        end
        EMIT: begin
          if (bus.rk_ready) begin
            if (rk_round == LAST) begin
              // rk_key/rk_round keep the final key while idle.
              state    <= IDLE;
              busy     <= 1'b0;
              rk_valid <= 1'b0;
              done     <= 1'b1;
`ifdef AES_KEY_STORE_EN
              keys_ready <= 1'b1;
`endif
            end else begin
              rk_key   <= next_key;
              rk_round <= rk_round + RIDX_W'(1);
              rcon     <= next_rcon;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AES_KEY_STORE_EN
  logic [127:0] store [ROUNDS+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i <= ROUNDS; i++) store[i] <= '0;
    end else if (state == EMIT && bus.rk_ready) begin
      store[rk_round] <= rk_key;
    end
  end

  always_comb begin
    bus.rd_key = '0;
    if (bus.rd_idx <= LAST) bus.rd_key = store[bus.rd_idx];
  end

  assign bus.keys_ready = keys_ready;
`endif

  assign bus.busy     = busy;
  assign bus.rk_valid = rk_valid;
  assign bus.rk_key   = rk_key;
  assign bus.rk_round = rk_round;
  assign bus.done     = done;

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: self-checking bench for aes_key_schedule. Known-answer
// round-key tables feed a scoreboard queue at each load; a monitor pops and
// compares on every accepted rk handshake, while the main sequence checks
// cycle timing, backpressure, ignored start, asynchronous abort and
// start-during-done. Key-store checks are built when AES_KEY_STORE_EN is set.
module tb_aes_key_schedule;
  localparam int unsigned ROUNDS = 10;
  localparam int unsigned RIDX_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_key_schedule_if #(.RIDX_W(RIDX_W)) bus();

  aes_key_schedule #(.ROUNDS(ROUNDS), .RIDX_W(RIDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [127:0]             key;
    logic [ROUNDS:0][127:0]   rk;
  } vec_t;

  typedef struct {
    logic [127:0]      key;
    logic [RIDX_W-1:0] round;
  } exp_t;

  vec_t vecs [2];
  exp_t sbq [$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted round key must match the queue head.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.rk_valid === 1'b1 && bus.rk_ready === 1'b1) begin
      exp_t e;
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_key: got round %0d key %h required no key", bus.rk_round, bus.rk_key);
      end else begin
        e = sbq.pop_front();
        check("sb_key", bus.rk_key, e.key);
        check("sb_round", 128'(bus.rk_round), 128'(e.round));
      end
    end
  end

  task automatic push_keys(input int v);
    for (int i = 0; i <= int'(ROUNDS); i++) begin
      exp_t e;
      e.key   = vecs[v].rk[i];
      e.round = RIDX_W'(i);
      sbq.push_back(e);
    end
  endtask

  task automatic start_key(input logic [127:0] key);
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.key_in = key;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Walks rounds first..ROUNDS with rk_ready high, one per cycle, then checks
  // the done pulse. Returns at the negedge of the done cycle. A start with a
  // foreign key is driven during round inj (use -1 for none).
  task automatic run_rounds(input int first, input int inj);
    for (int i = first; i <= int'(ROUNDS); i++) begin
      @(negedge clk);
      check("round_idx", 128'(bus.rk_round), 128'(i));
      check("rk_valid", 128'(bus.rk_valid), 128'(1));
      check("busy", 128'(bus.busy), 128'(1));
      if (i == inj) begin
        bus.start  = 1'b1;
        bus.key_in = '1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    @(negedge clk);
    check("done_pulse", 128'(bus.done), 128'(1));
    check("busy_end", 128'(bus.busy), 128'(0));
    check("valid_end", 128'(bus.rk_valid), 128'(0));
  endtask

  initial begin
    vecs[0].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vecs[0].rk  = {
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'hac7766f319fadc2128d12941575c006e,
      128'head27321b58dbad2312bf5607f8d292f, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hf2c295f27a96b9435935807a7359f67f, 128'ha0fafe1788542cb123a339392a6c7605,
      128'h2b7e151628aed2a6abf7158809cf4f3c
    };
    vecs[1].key = '0;
    vecs[1].rk  = {
      128'hb4ef5bcb3e92e21123e951cf6f8f188e, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
      128'h0ef903333ba9613897060a04511dfa9f, 128'h217517873550620bacaf6b3cc61bf09b,
      128'hec614b851425758c99ff09376ab49ba7, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
      128'hee06da7b876a1581759e42b27e91ee2b, 128'h90973450696ccffaf2f457330b0fac99,
      128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h62636363626363636263636362636363,
      128'h00000000000000000000000000000000
    };

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b1;
`ifdef AES_KEY_STORE_EN
    bus.rd_idx   = '0;
`endif
    #12;
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_valid", 128'(bus.rk_valid), 128'(0));
    check("rst_key", bus.rk_key, '0);
    check("rst_round", 128'(bus.rk_round), 128'(0));
    check("rst_done", 128'(bus.done), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // FIPS-197 key, full-rate expansion.
    push_keys(0);
    start_key(vecs[0].key);
    run_rounds(0, -1);
    @(negedge clk);
    check("done_one_cycle", 128'(bus.done), 128'(0));
    // Idle: rk_ready toggling has no effect and the final key is retained.
    for (int c = 0; c < 3; c++) begin
      bus.rk_ready = c[0];
      @(negedge clk);
      check("idle_key_hold", bus.rk_key, vecs[0].rk[ROUNDS]);
      check("idle_round_hold", 128'(bus.rk_round), 128'(ROUNDS));
      check("idle_valid", 128'(bus.rk_valid), 128'(0));
    end
    bus.rk_ready = 1'b1;
`ifdef AES_KEY_STORE_EN
    check("keys_ready", 128'(bus.keys_ready), 128'(1));
    bus.rd_idx = 4'd10; #1;
    check("rd_idx10", bus.rd_key, vecs[0].rk[10]);
    bus.rd_idx = 4'd0; #1;
    check("rd_idx0", bus.rd_key, vecs[0].rk[0]);
    bus.rd_idx = 4'd15; #1;
    check("rd_idx15", bus.rd_key, '0);
`endif

    // All-zero key, then a new load in the same cycle done is high.
    push_keys(1);
    start_key(vecs[1].key);
    run_rounds(0, -1);
    push_keys(0);
    bus.start  = 1'b1;
    bus.key_in = vecs[0].key;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    run_rounds(0, -1);

    // Backpressure on round 1 for three cycles.
    push_keys(0);
    start_key(vecs[0].key);
    @(posedge clk); #1;
    bus.rk_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_round", 128'(bus.rk_round), 128'(1));
      check("bp_key", bus.rk_key, vecs[0].rk[1]);
      check("bp_valid", 128'(bus.rk_valid), 128'(1));
      @(posedge clk); #1;
    end
    bus.rk_ready = 1'b1;
    run_rounds(1, -1);

    // start with another key while busy at round 4 is ignored.
    push_keys(0);
    start_key(vecs[0].key);
    run_rounds(0, 4);

    // Asynchronous abort at round 6, then zero key restarts from rcon=01.
    push_keys(0);
    start_key(vecs[0].key);
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      check("abort_round", 128'(bus.rk_round), 128'(i));
      if (i < 6) begin
        @(posedge clk); #1;
      end
    end
    #2 rst = 1'b1;
    #1;
    check("abort_valid", 128'(bus.rk_valid), 128'(0));
    check("abort_busy", 128'(bus.busy), 128'(0));
    check("abort_key", bus.rk_key, '0);
    check("abort_round0", 128'(bus.rk_round), 128'(0));
    check("abort_done", 128'(bus.done), 128'(0));
`ifdef AES_KEY_STORE_EN
    check("abort_keys_ready", 128'(bus.keys_ready), 128'(0));
`endif
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    push_keys(1);
    start_key(vecs[1].key);
    run_rounds(0, -1);

    @(negedge clk);
    check("sb_drained", 128'(sbq.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Sequential AES-128 key expansion that feeds the per-round key input of the encryption round datapath.
- Accepts a 128-bit cipher key and emits round keys 0..ROUNDS, one per handshake, in round order.
- Computes each next key on the fly from the current one, with no full key table by default.
- Sits directly upstream of the round pipeline; the round controller consumes rk_key together with rk_round.

Parameters:
- ROUNDS, 10: index of the last round key. Legal range is 1..10, because the rcon table holds 10 entries.
- RIDX_W, 4: width of rk_round. Must satisfy 2^RIDX_W > ROUNDS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  load request; sampled only in IDLE
- key_in  input  128  cipher key; byte 0 at bits [127:120]
- busy  output  1  high from the cycle after key acceptance until the final key is accepted
- rk_valid  output  1  rk_key and rk_round are valid
- rk_ready  input  1  consumer accepts the current key
- rk_key  output  128  current round key
- rk_round  output  RIDX_W  index of rk_key, 0..ROUNDS
- done  output  1  one-cycle pulse after round key ROUNDS is accepted

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0; state goes to IDLE; internal rcon goes to 8'h01.
  - Asserting rst mid-expansion aborts immediately. No further keys are emitted until a new start.
- States:
  - IDLE: busy=0, rk_valid=0.
    - start=1 at edge N: rk_key<=key_in, rk_round<=0, rcon<=01, go to EMIT.
    - At edge N+1 and later, rk_valid=1 and busy=1.
  - EMIT: rk_valid=1, busy=1.
    - On an edge with rk_valid & rk_ready and rk_round<ROUNDS: rk_key<=next(rk_key), rk_round<=rk_round+1, rcon<=xtime(rcon). Stay in EMIT.
    - On an edge with rk_valid & rk_ready and rk_round==ROUNDS: go to IDLE, rk_valid<=0, busy<=0, done<=1 for one cycle.
- next(k), with words w0=k[127:96], w1=k[95:64], w2=k[63:32], w3=k[31:0]:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - RotWord(w) = {w[23:0], w[31:24]}
  - SubWord applies the AES S-box to each byte; reuse the existing subbytes block at 32-bit width.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
- xtime(r) = {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00). This gives the sequence 01,02,04,08,10,20,40,80,1B,36.
- Throughput and latency:
  - With rk_ready held high, one key per cycle.
  - Key 0 is valid at N+1; key ROUNDS is valid at N+1+ROUNDS; done is high at N+2+ROUNDS.
- Backpressure: while rk_valid=1 and rk_ready=0, rk_key, rk_round, rk_valid and rcon hold stable.
- Boundary conditions:
  - start while busy=1 is ignored; key_in is don't-care.
  - start in the same cycle done is high is accepted, since the block is already in IDLE. Key 0 of the new key is then valid on the next cycle.
  - rk_ready while rk_valid=0 has no effect.
  - rk_key retains the final key after completion until the next load or reset.

Optional Feature:
- Macro: AES_KEY_STORE_EN.
- When defined:
  - Adds an internal array of ROUNDS+1 x 128-bit registers. Key i is written when it is accepted on the rk handshake.
  - Adds ports rd_idx (input, RIDX_W) and rd_key (output, 128). rd_key is a combinational read of entry rd_idx; idx > ROUNDS returns 0.
  - The array clears on rst. A new start does not clear it; entries are overwritten as the new keys are accepted.
  - Also adds output keys_ready (1 bit). It is set together with done and cleared by start or rst. It supports reverse-order decryption.
- When undefined: the array and all three ports are absent; behaviour is otherwise identical.

Test Plan:
1. FIPS-197 key, rk_ready=1:
   - Stimulus: key_in = 2b7e151628aed2a6abf7158809cf4f3c.
   - Round 0 equals the key, round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
   - Rounds appear on consecutive cycles N+1..N+11; done pulses at N+12.
2. All-zero key:
   - Round 1 = 62636363626363636263636362636363.
   - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
3. Backpressure: FIPS key, rk_ready=0 for 3 cycles while round 1 is presented.
   - rk_key stays a0fafe17...7605 and rk_round=1 for all 3 cycles.
   - The remaining sequence is unchanged.
4. start=1 with a different key while at round 4 → ignored; the remaining rounds match the FIPS vectors.
5. rst pulse while at round 6:
   - All outputs are 0 immediately (asynchronous).
   - A new start with the zero key then yields round 1 = 6263...6363, proving rcon was restored to 01.
6. With AES_KEY_STORE_EN defined, after test 1:
   - rd_idx=10 gives d014f9a8...0ca6; rd_idx=0 gives 2b7e1516...4f3c; rd_idx=15 gives 0.
   - keys_ready=1.
